// File: rtl/sd_pat_gen.sv
// sd_pat_gen: burst service-data pattern generator feeding the HSI framer byte by byte.
// Define SD_PAT_GEN_PRBS_EN to build the PRBS-31 generator behind mode 3.
module sd_pat_gen #(
  parameter int                      WORD_BYTES = 2,
  parameter int                      DP_LEN     = 64,
  parameter int                      DP_COUNT   = 4,
  parameter logic [8*WORD_BYTES-1:0] INI_VAL    = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       tx_en,
  input  logic       sending,
  output logic [7:0] d,
  output logic       d_rdy,
  output logic       tx_rdy,
  output logic       has_next_dp,
  output logic       done,
  output logic       ovr
);
  localparam int WW  = 8 * WORD_BYTES;
  localparam int BLW = $clog2(DP_LEN + 1);
  localparam int IW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, PKT, GAP} state_t;

  state_t         r_state,      w_state_nxt;
  logic [7:0]     r_pkt_left,   w_pkt_left_nxt;
  logic [BLW-1:0] r_bytes_left, w_bytes_left_nxt;
  logic [IW-1:0]  r_byte_idx,   w_byte_idx_nxt;
  logic [WW-1:0]  r_w,          w_w_nxt;
  logic [1:0]     r_mode,       w_mode_nxt;
  logic [7:0]     r_d,          w_d_nxt;
  logic           r_done,       w_done_nxt;
  logic           r_ovr,        w_ovr_nxt;
  logic [WW-1:0]  w_shifted;
  logic           w_can_accept;
  logic           w_accept;
  logic           w_restart;

`ifdef SD_PAT_GEN_PRBS_EN
  localparam logic [30:0] PRBS_SEED = 31'(INI_VAL) | 31'd1;
  logic [30:0] r_lfsr, w_lfsr_nxt;

  // x^31 + x^28 + 1, one output bit per shift, first bit lands in the word LSB.
  function automatic logic [30+WW:0] prbs_word(input logic [30:0] seed);
    logic [30:0] st;
    logic [WW-1:0] wd;
    st = seed;
    wd = '0;
    for (int i = 0; i < WW; i++) begin
      wd[i] = st[30] ^ st[27];
      st    = {st[29:0], wd[i]};
    end
    return {st, wd};
  endfunction

  assign w_restart = (r_mode == 2'd0);
`else
  // Mode 3 without the PRBS generator falls back to the restart-per-packet counter.
  assign w_restart = (r_mode == 2'd0) || (r_mode == 2'd3);
`endif

  // Acceptance ignores the ~sending mask of d_rdy, otherwise every strobe would be rejected.
  assign w_can_accept = (r_state == PKT) && tx_en && (r_bytes_left != '0);
  assign w_accept     = sending && w_can_accept;

  always_comb begin
    // NOTE: every next value starts from a hold/default so no path leaves it unassigned (no latch).
    w_state_nxt      = r_state;
    w_pkt_left_nxt   = r_pkt_left;
    w_bytes_left_nxt = r_bytes_left;
    w_byte_idx_nxt   = r_byte_idx;
    w_w_nxt          = r_w;
    w_mode_nxt       = r_mode;
    w_done_nxt       = 1'b0;
    w_ovr_nxt        = r_ovr | (sending & ~w_can_accept);
`ifdef SD_PAT_GEN_PRBS_EN
    w_lfsr_nxt       = r_lfsr;
`endif
    if (start) begin
      w_state_nxt    = ARMED;
      w_pkt_left_nxt = 8'(DP_COUNT);
      w_byte_idx_nxt = '0;
      w_w_nxt        = INI_VAL;
      w_mode_nxt     = mode;
      w_ovr_nxt      = 1'b0;
`ifdef SD_PAT_GEN_PRBS_EN
      w_lfsr_nxt     = PRBS_SEED;
      if (mode == 2'd3) {w_lfsr_nxt, w_w_nxt} = prbs_word(PRBS_SEED);
`endif
    end else begin
      case (r_state)
        ARMED: begin
          if (tx_en) begin
            w_state_nxt      = PKT;
            w_bytes_left_nxt = BLW'(DP_LEN);
            if (w_restart) w_w_nxt = INI_VAL;
          end
        end
        PKT: begin
          if (!tx_en) begin
            w_state_nxt = GAP;
          end else if (w_accept) begin
            w_bytes_left_nxt = r_bytes_left - BLW'(1);
            if (r_bytes_left == BLW'(1)) w_state_nxt = GAP;
            if (r_byte_idx == IW'(WORD_BYTES - 1)) begin
              w_byte_idx_nxt = '0;
              case (r_mode)
                2'd2: ;
`ifdef SD_PAT_GEN_PRBS_EN
                2'd3: {w_lfsr_nxt, w_w_nxt} = prbs_word(r_lfsr);
`endif
                default: w_w_nxt = r_w + WW'(1);
              endcase
            end else begin
              w_byte_idx_nxt = r_byte_idx + IW'(1);
            end
          end
        end
        GAP: begin
          if (!tx_en) begin
            w_pkt_left_nxt = r_pkt_left - 8'd1;
            if (r_pkt_left == 8'd1) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ARMED;
            end
          end
        end
        default: ;
      endcase
    end
    w_shifted = w_w_nxt >> {w_byte_idx_nxt, 3'b000};
    w_d_nxt   = w_shifted[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pkt_left   <= '0;
      r_bytes_left <= '0;
      r_byte_idx   <= '0;
      r_w          <= '0;
      r_mode       <= '0;
      r_d          <= '0;
      r_done       <= 1'b0;
      r_ovr        <= 1'b0;
`ifdef SD_PAT_GEN_PRBS_EN
      r_lfsr       <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the values from before this edge.
      r_state      <= w_state_nxt;
      r_pkt_left   <= w_pkt_left_nxt;
      r_bytes_left <= w_bytes_left_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_w          <= w_w_nxt;
      r_mode       <= w_mode_nxt;
      r_d          <= w_d_nxt;
      r_done       <= w_done_nxt;
      r_ovr        <= w_ovr_nxt;
`ifdef SD_PAT_GEN_PRBS_EN
      r_lfsr       <= w_lfsr_nxt;
`endif
    end
  end

  assign d           = r_d;
  assign done        = r_done;
  assign ovr         = r_ovr;
  assign d_rdy       = w_can_accept & ~sending;
  assign tx_rdy      = (r_state != IDLE);
  assign has_next_dp = (r_pkt_left > 8'd1);

endmodule

// File: tb/tb_sd_pat_gen.sv
// Self-checking bench for sd_pat_gen: directed and randomized bursts against an arithmetic byte model.
module tb_sd_pat_gen;
  localparam int          A_WB  = 2;
  localparam int          A_LEN = 64;
  localparam int          A_CNT = 4;
  localparam logic [15:0] A_INI = 16'h0000;
  localparam int          B_WB  = 4;
  localparam int          B_LEN = 8;
  localparam int          B_CNT = 2;
  localparam logic [31:0] B_INI = 32'hFFFF_FFFE;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_start, a_tx_en, a_sending;
  logic [1:0] a_mode;
  logic [7:0] a_d;
  logic       a_d_rdy, a_tx_rdy, a_has_next, a_done, a_ovr;
  logic       b_start, b_tx_en, b_sending;
  logic [1:0] b_mode;
  logic [7:0] b_d;
  logic       b_d_rdy, b_tx_rdy, b_has_next, b_done, b_ovr;

  int n_checks = 0;
  int n_fail   = 0;
  int a_md, a_k, a_cum, a_pkts;
  logic [7:0] prbs_bytes [0:511];

  always #5 clk = ~clk;

  sd_pat_gen #(.WORD_BYTES(A_WB), .DP_LEN(A_LEN), .DP_COUNT(A_CNT), .INI_VAL(A_INI)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .tx_en(a_tx_en), .sending(a_sending),
    .d(a_d), .d_rdy(a_d_rdy), .tx_rdy(a_tx_rdy), .has_next_dp(a_has_next), .done(a_done), .ovr(a_ovr)
  );

  sd_pat_gen #(.WORD_BYTES(B_WB), .DP_LEN(B_LEN), .DP_COUNT(B_CNT), .INI_VAL(B_INI)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .tx_en(b_tx_en), .sending(b_sending),
    .d(b_d), .d_rdy(b_d_rdy), .tx_rdy(b_tx_rdy), .has_next_dp(b_has_next), .done(b_done), .ovr(b_ovr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Byte k of the current packet, cum bytes into the burst, from the pattern rules alone.
  function automatic logic [7:0] exp_byte(input int wb, input logic [63:0] ini, input int md,
                                          input int k, input int cum);
    logic [63:0] word;
    int idx;
`ifdef SD_PAT_GEN_PRBS_EN
    if (md == 3) return prbs_bytes[cum];
`else
    if (md == 3) md = 0;
`endif
    idx  = (md == 1) ? cum : k;
    word = (md == 2) ? ini : ini + 64'(idx / wb);
    if (wb < 8) word = word & ((64'd1 << (8 * wb)) - 64'd1);
    word = word >> (8 * (idx % wb));
    return word[7:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d"},        a_d, 0);
    check({tag, "_d_rdy"},    a_d_rdy, 0);
    check({tag, "_tx_rdy"},   a_tx_rdy, 0);
    check({tag, "_has_next"}, a_has_next, 0);
    check({tag, "_done"},     a_done, 0);
    check({tag, "_ovr"},      a_ovr, 0);
  endtask

  task automatic a_do_start(input int md);
    a_mode  = 2'(md);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_md = md; a_k = 0; a_cum = 0; a_pkts = 0;
    check("start_tx_rdy", a_tx_rdy, 1);
    check("start_ovr", a_ovr, 0);
    check("start_has_next", a_has_next, A_CNT > 1);
    check("start_d", a_d, exp_byte(A_WB, A_INI, a_md, 0, 0));
  endtask

  // n accepted strobes with random idle cycles; assumes state PKT with tx_en high.
  task automatic a_strobes(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a_sending = 1'b0;
        #1;
        check("pkt_d_rdy_idle", a_d_rdy, 1);
        tick();
      end
      check("pkt_d", a_d, exp_byte(A_WB, A_INI, a_md, a_k, a_cum));
      a_sending = 1'b1;
      #1;
      check("pkt_d_rdy_masked", a_d_rdy, 0);
      tick();
      a_k++;
      a_cum++;
    end
    a_sending = 1'b0;
  endtask

  task automatic a_packet(input int n);
    logic last;
    a_tx_en = 1'b1;
    tick();
    a_k = 0;
    check("pkt_entry_d_rdy", a_d_rdy, 1);
    check("pkt_has_next", a_has_next, (A_CNT - a_pkts) > 1);
    a_strobes(n);
    if (n == A_LEN) check("pkt_end_d_rdy", a_d_rdy, 0);
    a_tx_en = 1'b0;
    tick();
    if (n < A_LEN) tick();
    a_pkts++;
    last = (a_pkts == A_CNT);
    check("pkt_close_done", a_done, last);
    check("pkt_close_tx_rdy", a_tx_rdy, !last);
    tick();
    check("pkt_done_one_cycle", a_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [30:0] s;
    logic fb;
    int n;
    s = 31'd1;
    for (int i = 0; i < 512; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = s[30] ^ s[27];
        s  = {s[29:0], fb};
        prbs_bytes[i][b] = fb;
      end
    end

    rst = 1'b1;
    a_start = 0; a_tx_en = 0; a_sending = 0; a_mode = 0;
    b_start = 0; b_tx_en = 0; b_sending = 0; b_mode = 0;
    tick(); tick();
    check_reset_outputs("rst_held");
    rst = 1'b0;
    tick();
    check_reset_outputs("rst_released");

    // Defaults, mode 0: four full packets of 00 00 01 00 ... 1F 00.
    a_do_start(0);
    for (int p = 0; p < A_CNT; p++) a_packet(A_LEN);

    // Aborted first packet counts as sent; the next window restarts at INI_VAL.
    a_do_start(0);
    a_packet(10);
    check("abort_has_next", a_has_next, 1);
    for (int p = 1; p < A_CNT; p++) a_packet(A_LEN);

    // Extra strobe after the last byte sets sticky ovr and leaves d alone.
    a_do_start(1);
    a_tx_en = 1'b1;
    tick();
    a_k = 0;
    a_strobes(A_LEN);
    check("ovr_pre", a_ovr, 0);
    a_sending = 1'b1;
    tick();
    a_sending = 1'b0;
    check("ovr_set", a_ovr, 1);
    check("ovr_d_hold", a_d, exp_byte(A_WB, A_INI, 1, A_LEN, A_LEN));
    a_tx_en = 1'b0;
    tick();
    check("ovr_sticky", a_ovr, 1);
    a_do_start(0);

    // start together with sending mid-packet re-arms and drops the strobe.
    a_do_start(1);
    a_tx_en = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      a_sending = 1'b1;
      tick();
    end
    a_start = 1'b1;
    a_sending = 1'b1;
    tick();
    a_start = 1'b0;
    a_sending = 1'b0;
    a_md = 1; a_k = 0; a_cum = 0; a_pkts = 0;
    check("restart_tx_rdy", a_tx_rdy, 1);
    check("restart_has_next", a_has_next, 1);
    check("restart_d", a_d, exp_byte(A_WB, A_INI, 1, 0, 0));
    check("restart_d_rdy", a_d_rdy, 0);
    for (int p = 0; p < A_CNT; p++) a_packet(A_LEN);

    // Randomized bursts: random mode, word-aligned random aborts, random strobe spacing.
    for (int r = 0; r < 3; r++) begin
      a_do_start(int'($urandom_range(0, 3)));
      for (int p = 0; p < A_CNT; p++) begin
        n = ($urandom_range(0, 3) != 0) ? A_LEN : 2 * int'($urandom_range(1, A_LEN / 2 - 1));
        a_packet(n);
      end
    end

    // Mode 3: PRBS-31 stream with the macro, mode-0 counter without it.
    a_do_start(3);
    for (int p = 0; p < 2; p++) a_packet(A_LEN);

    // Wide words, mode 1: FE FF FF FF FF FF FF FF then 00 00 00 00 01 00 00 00.
    b_mode = 2'd1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int p = 0; p < B_CNT; p++) begin
      b_tx_en = 1'b1;
      tick();
      check("b_has_next", b_has_next, p < B_CNT - 1);
      for (int k = 0; k < B_LEN; k++) begin
        check("b_d", b_d, exp_byte(B_WB, B_INI, 1, k, p * B_LEN + k));
        b_sending = 1'b1;
        tick();
      end
      b_sending = 1'b0;
      b_tx_en = 1'b0;
      tick();
      check("b_done", b_done, p == B_CNT - 1);
    end
    check("b_ovr", b_ovr, 0);

    // Reset mid-burst clears every output immediately.
    a_do_start(0);
    a_sending = 1'b1;
    tick();
    a_sending = 1'b0;
    check("armed_strobe_ovr", a_ovr, 1);
    a_tx_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      a_sending = 1'b1;
      tick();
    end
    a_sending = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    a_tx_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_pat_gen.md
# sd_pat_gen

Parametrised service-data pattern generator for the HSI transmit path; successor to the fixed 16-bit service-data generator. On a `start` pulse it arms a burst of `DP_COUNT` data packets, each `DP_LEN` bytes long. It serves them byte-by-byte to the HSI framer over a `tx_en`/`sending` handshake, with word width and pattern mode selectable. Fully synchronous single-clock design; sits between the command decoder, which issues `start`, and the HSI serialiser.

## Interface

Parameters:
- `WORD_BYTES`, default 2: bytes per pattern word; legal 1..8.
- `DP_LEN`, default 64: bytes per data packet; must be a multiple of `WORD_BYTES`.
- `DP_COUNT`, default 4: packets per burst; legal 1..255.
- `INI_VAL`, default 0: initial pattern word, `8*WORD_BYTES` bits.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: clock.
- `rst` input 1: asynchronous active-high reset.
- `start` input 1: one-cycle pulse; arms, or re-arms, a burst.
- `mode` input 2: pattern mode, sampled on `start`.
- `tx_en` input 1: packet window from framer; high for the duration of one packet.
- `sending` input 1: one-cycle strobe; framer has consumed the byte on `d`.
- `d` output 8: current byte.
- `d_rdy` output 1: byte on `d` is valid for consumption.
- `tx_rdy` output 1: burst armed or in progress.
- `has_next_dp` output 1: at least one packet remains after the current one.
- `done` output 1: one-cycle pulse when the last packet closes.
- `ovr` output 1: sticky; a `sending` strobe arrived with `d_rdy` low.

## Operation

- States: `IDLE`, `ARMED`, `PKT`, `GAP`.
- `IDLE` -> `ARMED` on `start`. This loads `pkt_left = DP_COUNT`, word register `w = INI_VAL`, `byte_idx = 0`, latches `mode`, and clears `ovr`.
- `ARMED` -> `PKT` on `tx_en` high. This loads `bytes_left = DP_LEN`.
- `PKT`:
  - Each `sending` with `d_rdy` high: `byte_idx` increments; at `WORD_BYTES-1` it wraps to 0 and `w` advances per mode; `bytes_left` decrements.
  - `bytes_left` reaching 0 -> `GAP`.
  - `tx_en` falling in `PKT` (aborted packet) -> `GAP`; the packet counts as sent.
- `GAP`: on `tx_en` low, `pkt_left` decrements. If the new value is 0 -> `IDLE` and pulse `done`; otherwise -> `ARMED`.
- Byte order: `d = w[8*byte_idx +: 8]`, least-significant byte first.
- Modes:
  - 0: counter, `w` restarts at `INI_VAL` at each packet entry.
  - 1: counter, continuous across packets.
  - 2: constant `INI_VAL`.
  - 3: PRBS, only when the macro is defined.
- Counter arithmetic is `8*WORD_BYTES` bits and wraps modulo 2^(8*WORD_BYTES).
- `d_rdy = (state == PKT) & tx_en & ~sending & (bytes_left != 0)`.
- `tx_rdy = (state != IDLE)`.
- `has_next_dp = (pkt_left > 1)`.
- `sending` while `d_rdy` is low sets `ovr`; the strobe is otherwise ignored and `d` holds its value.
- `start` in any non-`IDLE` state aborts the burst and re-arms as from `IDLE`. `start` takes priority over a simultaneous `sending` or `tx_en` edge.

## Timing

- Reset values: state `IDLE`; `d = 0`, `d_rdy = 0`, `tx_rdy = 0`, `has_next_dp = 0`, `done = 0`, `ovr = 0`; all counters 0.
- `d`, `done` and `ovr` are registered.
- `d_rdy`, `tx_rdy` and `has_next_dp` are combinational from registered state and the `tx_en`/`sending` inputs.
- `tx_rdy` rises the cycle after `start`.
- `PKT` is entered the cycle after `tx_en` is sampled high. The first `d_rdy` appears in that same cycle, and `d` already holds byte 0.
- `d` updates one cycle after each accepted `sending`. Back-to-back `sending` on consecutive cycles is legal, because the `~sending` term masks `d_rdy` only during the strobe cycle.
- `done` is high for exactly one cycle, the cycle in which state returns to `IDLE`.
- `rst` mid-burst returns every output to its reset value within the same cycle.

## Configuration

- Macro `SD_PAT_GEN_PRBS_EN`.
- Defined: mode 3 is PRBS-31 (x^31 + x^28 + 1). The LFSR is seeded with `INI_VAL | 1` on `start` and advances once per word, shifting `8*WORD_BYTES` bits per advance. The seed is not reloaded between packets.
- Undefined: the LFSR logic is absent and mode 3 behaves as mode 0.

## Test plan

- Defaults, mode 0, `start`, then 4 `tx_en` windows of 64 strobes each -> every packet carries bytes 00 00 01 00 02 00 … 1F 00. `has_next_dp` reads 1,1,1,0 across the packets. `done` pulses once after the fourth `tx_en` fall.
- Mode 1, `WORD_BYTES=4`, `DP_LEN=8`, `DP_COUNT=2`, `INI_VAL=0xFFFFFFFE` -> packet 1 is FE FF FF FF FF FF FF FF; packet 2 is 00 00 00 00 01 00 00 00 (wrap-around).
- `tx_en` dropped after 10 of 64 strobes in packet 1 -> the packet is counted as sent, `pkt_left` becomes 3, and the next window restarts at `INI_VAL`.
- Extra `sending` after the last byte of a packet -> `ovr` = 1 and `d` unchanged. The next `start` clears `ovr`.
- `start` asserted on the same cycle as a `sending` mid-burst -> state `ARMED`, `w = INI_VAL`, `pkt_left = DP_COUNT`, and the strobe is not counted.
- With `SD_PAT_GEN_PRBS_EN` defined, mode 3, `WORD_BYTES=1`, `INI_VAL=0` -> the byte sequence matches the PRBS-31 golden model seeded with 1. Without the macro, the same stimulus yields the mode-0 sequence.
